fb_capture_ctrl: RTL

FB_CAPTURE_CTRL -- requirements
Module: fb_capture_ctrl

---
 rtl/fb_capture_ctrl_if.sv | 41 ++++
 rtl/fb_capture_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fb_capture_ctrl_if.sv
// fb_capture_ctrl_if
// Bundles the camera-side inputs, the command handshake and the framebuffer
// write / status outputs of fb_capture_ctrl.
//   vsync                           : camera vsync level
//   pix_valid/pix_data/pix_row/pix_col : pixel strobe, RGB565 data, coordinates
//   cmd_valid/cmd/cmd_ready         : command handshake (0 RUN, 1 FREEZE, 2 SNAP, 3 CLEAR_ERR)
//   wr_valid/wr_addr/wr_data        : framebuffer write port
//   filt_rst                        : one-cycle edge-filter realign pulse
//   state/frame_cnt                 : controller state and completed-frame count
//   err_timeout/err_range           : sticky error flags
// The slave modport is the controller; the master modport is the camera/host side.
interface fb_capture_ctrl_if;
  logic        vsync;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic [9:0]  pix_row;
  logic [9:0]  pix_col;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic        cmd_ready;
  logic        wr_valid;
  logic [14:0] wr_addr;
  logic [15:0] wr_data;
  logic        filt_rst;
  logic [1:0]  state;
  logic [7:0]  frame_cnt;
  logic        err_timeout;
  logic        err_range;

  modport master (
    output vsync, pix_valid, pix_data, pix_row, pix_col, cmd_valid, cmd,
    input  cmd_ready, wr_valid, wr_addr, wr_data, filt_rst, state, frame_cnt,
           err_timeout, err_range
  );

  modport slave (
    input  vsync, pix_valid, pix_data, pix_row, pix_col, cmd_valid, cmd,
    output cmd_ready, wr_valid, wr_addr, wr_data, filt_rst, state, frame_cnt,
           err_timeout, err_range
  );
endinterface

// File: rtl/fb_capture_ctrl.sv
// fb_capture_ctrl
// Frame capture controller: tracks camera frames from vsync rising edges,
// gates pixel writes into a P_WIDTH x P_HEIGHT framebuffer, applies
// RUN/FREEZE/SNAP commands on frame boundaries and watches for a stalled
// camera.
// Ports:
//   i_clk : pixel clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : fb_capture_ctrl_if.slave (camera inputs, commands, write port, status)
module fb_capture_ctrl #(
  parameter int unsigned P_WIDTH   = 160,
  parameter int unsigned P_HEIGHT  = 120,
  parameter int unsigned P_TIMEOUT = 2_000_000
) (
  input logic              i_clk,
  input logic              i_rst,
  fb_capture_ctrl_if.slave bus
);

  localparam int unsigned WD_W = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(P_TIMEOUT - 1);

  localparam logic [1:0] CMD_RUN    = 2'd0;
  localparam logic [1:0] CMD_FREEZE = 2'd1;
  localparam logic [1:0] CMD_SNAP   = 2'd2;
  localparam logic [1:0] CMD_CLEAR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_CAPTURE  = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic            vsync_q_r;
  logic [1:0]      mode_r, mode_s;
  logic            pend_valid_r, pend_valid_s;
  logic [1:0]      pend_cmd_r, pend_cmd_s;
  logic [WD_W-1:0] wd_r, wd_s;
  logic [7:0]      frame_cnt_r, frame_cnt_s;
  logic            err_timeout_r, err_timeout_s;
  logic            err_range_r, err_range_s;
  logic            filt_rst_r, filt_rst_s;
  logic            wr_valid_r, wr_valid_s;
  logic [14:0]     wr_addr_r, wr_addr_s;
  logic [15:0]     wr_data_r;

  logic       sof_s, new_cmd_s, clear_s, active_s, frame_end_s, timeout_s;
  logic       in_range_s, range_hit_s, idle_go_s;
  logic [1:0] eff_mode_s, idle_cmd_s;

  // Event decode, pixel gating and next-state / next-output logic
  always_comb begin
    sof_s       = bus.vsync & ~vsync_q_r;
    clear_s     = bus.cmd_valid & (bus.cmd == CMD_CLEAR);
    new_cmd_s   = bus.cmd_valid & (bus.cmd != CMD_CLEAR);
    active_s    = (state_r != ST_IDLE);
    frame_end_s = (state_r == ST_CAPTURE) & sof_s;
    timeout_s   = active_s & ~sof_s & (wd_r == WD_LAST);
    // A queued command decides what the frame that is ending turns into.
    eff_mode_s  = pend_valid_r ? pend_cmd_r : mode_r;
    // In IDLE a command left in the slot by a frame end is served first.
    idle_cmd_s  = pend_valid_r ? pend_cmd_r : bus.cmd;
    idle_go_s   = (pend_valid_r | new_cmd_s) &
                  ((idle_cmd_s == CMD_RUN) | (idle_cmd_s == CMD_SNAP));

    in_range_s  = (32'(bus.pix_col) < P_WIDTH) & (32'(bus.pix_row) < P_HEIGHT);
    wr_valid_s  = bus.pix_valid & (state_r == ST_CAPTURE) & in_range_s;
    range_hit_s = bus.pix_valid & (state_r == ST_CAPTURE) & ~in_range_s;
    wr_addr_s   = 15'(32'(bus.pix_row) * P_WIDTH + 32'(bus.pix_col));

    // New error events win over a coincident CLEAR_ERR.
    err_range_s   = (err_range_r & ~clear_s) | range_hit_s;
    err_timeout_s = (err_timeout_r & ~clear_s) | timeout_s;

    state_s      = state_r;
    mode_s       = mode_r;
    pend_valid_s = pend_valid_r;
    pend_cmd_s   = pend_cmd_r;
    wd_s         = wd_r;
    frame_cnt_s  = frame_cnt_r;
    filt_rst_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        wd_s         = '0;
        pend_valid_s = 1'b0;
        if (idle_go_s) begin
          state_s = ST_WAIT_SOF;
          mode_s  = idle_cmd_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_SOF, ST_CAPTURE: begin
        if (timeout_s) begin
          state_s      = ST_IDLE;
          wd_s         = '0;
          pend_valid_s = 1'b0;
        end else if (frame_end_s) begin
          frame_cnt_s  = frame_cnt_r + 8'd1;
          wd_s         = '0;
          mode_s       = eff_mode_s;
          pend_valid_s = new_cmd_s;
          pend_cmd_s   = new_cmd_s ? bus.cmd : pend_cmd_r;
          if (eff_mode_s == CMD_RUN) begin
            state_s    = ST_CAPTURE;
            filt_rst_s = 1'b1;
          end else begin
            state_s    = ST_IDLE;
          end
        end else begin
          if (sof_s) begin
            state_s    = ST_CAPTURE;
            filt_rst_s = 1'b1;
            wd_s       = '0;
          end else begin
            wd_s       = wd_r + WD_W'(1);
          end
          if (new_cmd_s && !pend_valid_r) begin
            pend_valid_s = 1'b1;
            pend_cmd_s   = bus.cmd;
          end else begin
            pend_valid_s = pend_valid_r;
          end
        end
      end
      default: begin
        state_s      = ST_IDLE;
        wd_s         = '0;
        pend_valid_s = 1'b0;
      end
    endcase
  end

  // State, status and write-port registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r       <= ST_IDLE;
      vsync_q_r     <= 1'b0;
      mode_r        <= CMD_FREEZE;
      pend_valid_r  <= 1'b0;
      pend_cmd_r    <= CMD_RUN;
      wd_r          <= '0;
      frame_cnt_r   <= 8'd0;
      err_timeout_r <= 1'b0;
      err_range_r   <= 1'b0;
      filt_rst_r    <= 1'b0;
      wr_valid_r    <= 1'b0;
      wr_addr_r     <= 15'd0;
      wr_data_r     <= 16'd0;
    end else begin
      state_r       <= state_s;
      vsync_q_r     <= bus.vsync;
      mode_r        <= mode_s;
      pend_valid_r  <= pend_valid_s;
      pend_cmd_r    <= pend_cmd_s;
      wd_r          <= wd_s;
      frame_cnt_r   <= frame_cnt_s;
      err_timeout_r <= err_timeout_s;
      err_range_r   <= err_range_s;
      filt_rst_r    <= filt_rst_s;
      wr_valid_r    <= wr_valid_s;
      wr_addr_r     <= wr_addr_s;
      wr_data_r     <= bus.pix_data;
    end
  end

  assign bus.state       = state_r;
  assign bus.cmd_ready   = ~pend_valid_r;
  assign bus.wr_valid    = wr_valid_r;
  assign bus.wr_addr     = wr_addr_r;
  assign bus.wr_data     = wr_data_r;
  assign bus.filt_rst    = filt_rst_r;
  assign bus.frame_cnt   = frame_cnt_r;
  assign bus.err_timeout = err_timeout_r;
  assign bus.err_range   = err_range_r;

endmodule
